// File: rtl/csel_addsub_pipe.sv
// Pipelined carry-select adder/subtractor with signed saturation.
// Each SEG-bit segment is resolved in its own stage; a valid/ready handshake
// stalls the whole pipe as one unit.
module csel_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             ci,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  // Ripple one segment; returns {carry into MSB, carry out, segment sum}.
  function automatic logic [SEG+1:0] seg_ripple(input logic [SEG-1:0] a,
                                                input logic [SEG-1:0] b,
                                                input logic           cin);
    logic [SEG-1:0] s;
    logic           c;
    logic           ctop;
    s    = '0;
    c    = cin;
    ctop = cin;
    for (int unsigned j = 0; j < SEG; j++) begin
      if (j == SEG - 1) ctop = c;
      s[j] = a[j] ^ b[j] ^ c;
      c    = (a[j] & b[j]) | ((a[j] ^ b[j]) & c);
    end
    return {ctop, c, s};
  endfunction

  // Per-stage pipeline slots. Operands travel whole; stage k only reads its
  // own segment. r_s accumulates resolved lower segments (output deskew).
  // Only the saturate bit of mode is needed past operand preparation.
  logic             r_v   [NSEG];
  logic             r_sat [NSEG];
  logic             r_c   [NSEG];
  logic [WIDTH-1:0] r_a   [NSEG];
  logic [WIDTH-1:0] r_b   [NSEG];
  logic [WIDTH-1:0] r_s   [NSEG];

  logic             w_adv;
  logic [SEG+1:0]   w_r0    [NSEG];
  logic [SEG+1:0]   w_r1    [NSEG];
  logic [SEG-1:0]   w_sel_s [NSEG];
  logic             w_sel_c [NSEG];
  logic [WIDTH-1:0] w_part  [NSEG];
  logic             w_top;
  logic             w_ovf;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // Both carry hypotheses per segment, then select on the registered carry.
  always_comb begin
    for (int unsigned k = 0; k < NSEG; k++) begin
      w_r0[k]    = seg_ripple(r_a[k][k*SEG +: SEG], r_b[k][k*SEG +: SEG], 1'b0);
      w_r1[k]    = seg_ripple(r_a[k][k*SEG +: SEG], r_b[k][k*SEG +: SEG], 1'b1);
      w_sel_s[k] = r_c[k] ? w_r1[k][SEG-1:0] : w_r0[k][SEG-1:0];
      w_sel_c[k] = r_c[k] ? w_r1[k][SEG]     : w_r0[k][SEG];
      w_part[k]  = r_s[k];
      w_part[k][k*SEG +: SEG] = w_sel_s[k];
    end
  end

  // Final-stage overflow detection and saturation.
  always_comb begin
    w_top = r_c[NSEG-1] ? w_r1[NSEG-1][SEG+1] : w_r0[NSEG-1][SEG+1];
    w_ovf = w_top ^ w_sel_c[NSEG-1];
    w_raw = w_part[NSEG-1];
    w_res = w_raw;
    if (r_sat[NSEG-1] && w_ovf) begin
      // Raw sign 1 after overflow means the true result was positive.
      w_res = w_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                             : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // Pipeline advance: operand prep into stage 0, shift all stages, output regs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        r_v[k]   <= 1'b0;
        r_sat[k] <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
    end else if (w_adv) begin
      r_v[0]   <= in_valid;
      r_sat[0] <= mode[1];
      r_c[0]   <= mode[0] ? 1'b1 : ci;
      r_a[0]   <= opa;
      r_b[0]   <= mode[0] ? ~opb : opb;
      r_s[0]   <= '0;
      for (int unsigned k = 1; k < NSEG; k++) begin
        r_v[k]   <= r_v[k-1];
        r_sat[k] <= r_sat[k-1];
        r_c[k]   <= w_sel_c[k-1];
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_s[k]   <= w_part[k-1];
      end
      out_valid <= r_v[NSEG-1];
      sum       <= w_res;
      co        <= w_sel_c[NSEG-1];
      ovf       <= w_ovf;
    end
  end

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Self-checking bench for csel_addsub_pipe (WIDTH=32, SEG=8).
module tb_csel_addsub_pipe;

  localparam int WIDTH = 32;
  localparam int SEG   = 8;
  localparam int NSEG  = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             ci;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_rx   = 0;
  logic [33:0] q[$];

  csel_addsub_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .ci(ci), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: {co, ovf, result} from plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic [1:0] m);
    longint sa, sb, full, ua;
    logic [31:0] raw, res;
    logic cout, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m[0]) begin
      full = sa - sb;
      raw  = a - b;
      cout = (a >= b);
    end else begin
      full = sa + sb + longint'({63'b0, c});
      raw  = a + b + {31'b0, c};
      ua   = longint'({32'b0, a}) + longint'({32'b0, b}) + longint'({63'b0, c});
      cout = (ua > 64'sh0FFFFFFFF);
    end
    v   = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    res = raw;
    if (m[1] && v) res = (full > 0) ? 32'h7FFFFFFF : 32'h80000000;
    return {cout, v, res};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, scoreboard drain/accept, then step past posedge.
  task automatic tick(output bit acc);
    bit stalled;
    logic [33:0] e;
    acc = 1'b0;
    @(negedge clk);
    check("in_ready", {63'b0, in_ready}, {63'b0, (!out_valid || out_ready)});
    if (rst_n) begin
      if (q.size() == 0) check("idle_out_valid", {63'b0, out_valid}, 64'd0);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        check("result", {30'b0, co, ovf, sum}, {30'b0, e});
        n_rx++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(opa, opb, ci, mode));
        acc = 1'b1;
      end
    end
    stalled = rst_n && out_valid && !out_ready && (q.size() > 0);
    @(posedge clk);
    #1;
    if (!rst_n) q.delete();
    else if (stalled)
      check("stall_hold", {29'b0, out_valid, co, ovf, sum}, {29'b0, 1'b1, q[0]});
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [1:0] m, input string tag);
    bit acc;
    int n;
    opa = a; opb = b; ci = c; mode = m;
    in_valid = 1'b1; out_ready = 1'b1;
    tick(acc);
    check({tag, "_accept"}, {63'b0, acc}, 64'd1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick(acc);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NSEG));
    tick(acc);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit acc;
    int i, seen, stall, rx0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opa = '0; opb = '0; ci = 1'b0; mode = 2'b00;
    tick(acc); tick(acc);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_sum", {32'b0, sum}, 64'd0);
    check("reset_co_ovf", {62'b0, co, ovf}, 64'd0);
    rst_n = 1'b1;
    tick(acc);
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);

    // Directed cases from the plan.
    run_one(32'hFFFFFFFF, 32'h00000001, 1'b0, 2'b00, "add_wrap");
    run_one(32'h00FFFFFF, 32'h00000000, 1'b1, 2'b00, "csel_ci");
    run_one(32'h12345678, 32'h9ABCDEF0, 1'b0, 2'b00, "add_mix");
    run_one(32'd5, 32'd7, 1'b0, 2'b01, "sub_borrow");
    run_one(32'd7, 32'd5, 1'b0, 2'b01, "sub_noborrow");
    run_one(32'h7FFFFFFF, 32'd1, 1'b0, 2'b10, "sat_pos");
    run_one(32'h80000000, 32'd1, 1'b0, 2'b11, "sat_neg");
    run_one(32'hFFFFFFFF, 32'd1, 1'b0, 2'b10, "sat_none");
    run_one(32'h80000000, 32'h80000000, 1'b1, 2'b00, "add_ovf_raw");
    run_one(32'h00000000, 32'h80000000, 1'b1, 2'b01, "sub_ci_ignored");

    // Backpressure: 8 beats, 6 stalled cycles after first result.
    i = 0; seen = 0; stall = 0; rx0 = n_rx;
    for (int c = 0; c < 80 && (n_rx - rx0) < 8; c++) begin
      if (seen != 0 && stall == 0)
        check("bp_no_gap", {63'b0, out_valid}, 64'd1);
      in_valid = (i < 8); opa = i; opb = i; ci = 1'b0; mode = 2'b00;
      out_ready = (stall == 0);
      tick(acc);
      if (acc) i++;
      if (seen == 0 && out_valid) begin
        seen = 1; stall = 6;
      end else if (stall > 0) begin
        stall--;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_accepted", 64'(i), 64'd8);
    check("bp_received", 64'(n_rx - rx0), 64'd8);

    // Reset mid-flight discards in-flight beats.
    tick(acc); tick(acc);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opa = 32'h100 + k; opb = 32'h1; mode = 2'b00;
      tick(acc);
    end
    in_valid = 1'b0; rst_n = 1'b0;
    tick(acc);
    rst_n = 1'b1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_sum", {32'b0, sum}, 64'd0);
    check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    for (int k = 0; k < 10; k++) tick(acc);

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      opa = rnd_op(); opb = rnd_op();
      ci = 1'($urandom_range(0, 1)); mode = 2'($urandom_range(0, 3));
      tick(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) tick(acc);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csel_addsub_pipe.md
Name: csel_addsub_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor; the successor to our fixed 32-bit single-cycle carry-select adder.
- Operands are split into NSEG = WIDTH/SEG equal segments, and each segment occupies one pipeline stage. Within a stage, the segment sum is computed for carry-in 0 and carry-in 1 in parallel, and the carry registered from the previous stage selects between them.
- Adds subtract and signed-saturate modes, plus valid/ready flow control on both sides.
- Sits between operand sources (register file, accumulators) and downstream consumers in the datapath.

Parameters:
- WIDTH, 32: operand/result width. Must be a multiple of SEG and at least 2*SEG.
- SEG, 8: bits per carry-select segment; one pipeline stage per segment.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- opa  in  WIDTH  operand A.
- opb  in  WIDTH  operand B.
- ci  in  1  carry-in; used in add modes only.
- mode  in  2  operation select:
  - 00: add, result = A+B+ci.
  - 01: sub, result = A-B.
  - 10: signed saturating add, A+B+ci.
  - 11: signed saturating sub, A-B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- co  out  1  carry-out of bit WIDTH-1. Add: carry. Sub: 1 = no borrow (A>=B unsigned).
- ovf  out  1  signed overflow of the unsaturated result.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All stage valid bits, out_valid, sum, co and ovf go to 0; in_ready=1 after reset.
  - Reset mid-operation discards every in-flight beat. No partial result is ever presented.
- Flow control:
  - The whole pipeline advances when adv = ~out_valid | out_ready.
  - in_ready = adv, combinational from out_valid/out_ready only. It never depends on in_valid.
  - A beat is accepted when in_valid & in_ready.
  - When adv=0, all stages hold: data, carries and valids are unchanged.
- Latency and throughput:
  - A beat accepted at edge t appears with out_valid=1 after edge t+NSEG when adv stays 1.
  - Throughput is one beat per cycle.
  - Beats leave in order with no loss or duplication.
- Operand preparation (at accept):
  - Subtract modes use B' = ~opb with carry-in 1; add modes use B' = opb with carry-in ci.
  - mode is captured with the beat and travels down the pipe.
- Stage k (k=0..NSEG-1) handles bits [k*SEG+SEG-1 : k*SEG]:
  - Input skew: stage k receives operand bits delayed by k stages.
  - It computes sum0/carry0 (cin=0) and sum1/carry1 (cin=1) by ripple generate/propagate inside the segment.
  - It selects on the carry registered by stage k-1; stage 0 uses the prepared carry-in.
  - It registers the selected segment sum, the carry-out, and the beat's mode and valid.
  - Output deskew: completed segment sums are held alongside the beat so all WIDTH bits emerge together.
- Overflow and saturation:
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, computed in the last stage.
  - co = carry out of bit WIDTH-1, unsaturated, in all modes.
  - Modes 00/01: sum is the raw result modulo 2^WIDTH.
  - Modes 10/11 with ovf=1: sum = 0x7FF..F if the raw result sign bit is 1 (positive overflow), else 0x800..0. With ovf=0, sum is the raw result.
  - ovf is reported in all modes.
- Output holding: sum/co/ovf are stable while out_valid=1 and out_ready=0. They update only on an advance.
- Simultaneous accept and drain: when the pipe is full and out_ready=1, a new beat enters in the same cycle the oldest leaves. There are no bubbles.
- Width wrap: results wrap modulo 2^WIDTH in non-saturating modes; carries never leak between beats.

Test Plan (WIDTH=32, SEG=8, NSEG=4):
- Add wrap: mode=00, opa=0xFFFFFFFF, opb=0x00000001, ci=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x00000000, co=1, ovf=0.
- Cross-segment carry select: mode=00, opa=0x00FFFFFF, opb=0, ci=1 -> sum=0x01000000, co=0. Separately, opa=0x12345678, opb=0x9ABCDEF0, ci=0 -> sum=0xACF13568, co=0.
- Sub and borrow: mode=01, opa=5, opb=7 -> sum=0xFFFFFFFE, co=0, ovf=0. Separately, opa=7, opb=5 -> sum=2, co=1.
- Saturation:
  - mode=10, opa=0x7FFFFFFF, opb=1 -> sum=0x7FFFFFFF, ovf=1.
  - mode=11, opa=0x80000000, opb=1 -> sum=0x80000000, ovf=1.
  - mode=10, opa=0xFFFFFFFF, opb=1 -> sum=0, ovf=0.
- Backpressure:
  - Stream 8 back-to-back beats (opa=i, opb=i, i=0..7) with out_ready=0 for 6 cycles after the first out_valid.
  - Required: in_ready=0 while stalled, first result held stable, then sums 0,2,...,14 in order with no gaps once out_ready=1.
- Reset mid-flight: accept 3 beats, assert rst_n=0 for one cycle -> out_valid=0, sum=0, in_ready=1 the next cycle; none of the 3 results ever appear.
